video_pll_lock_ctrl: RTL and testbench
======================================

Name: video_pll_lock_ctrl

Overview:
- Controller for the video PLL's reset/lock interface. It drives the PLL's rst input and consumes its asynchronous locked output.
- Runs on the free-running 50 MHz board clock, because the PLL output clock is not valid until lock.
- Pulses PLL reset, waits for lock with a timeout and retry, and requires lock to stay stable before releasing the video-domain reset.
- Detects loss of lock and keeps status counters for software.

Parameters:
SYNC_STAGES, 2, flops in the locked_in synchronizer (>=2)
PLL_RST_CYCLES, 16, cycles pll_rst is held high per reset pulse (must be > SYNC_STAGES)
LOCK_TIMEOUT, 65536, cycles allowed in WAIT_LOCK before PLL reset is retried
HOLDOFF_CYCLES, 1024, consecutive synchronized-locked cycles required before release
CNT_W, 8, width of each status counter

Ports:
refclk  input  1  50 MHz free-running clock; all logic is on its rising edge
rst  input  1  synchronous, active-high reset
locked_in  input  1  PLL locked output, asynchronous to refclk
clr_status  input  1  synchronous clear of counters and sticky flag
pll_rst  output  1  reset to the PLL, active-high
video_rst  output  1  reset for the video domain, active-high, high unless state==RUN
ready  output  1  high only in RUN
lock_lost_sticky  output  1  set when lock drops while in RUN
lock_lost_count  output  CNT_W  number of RUN->lock-loss events, saturating
timeout_count  output  CNT_W  number of WAIT_LOCK timeouts, saturating

Behaviour:
- Synchronizer: locked_in passes through SYNC_STAGES flops to give lk_s. It is the only consumer of locked_in. On rst the synchronizer flops clear to 0.
- Moore outputs decoded from the registered state:
  - pll_rst = (state==PLL_RESET)
  - video_rst = (state!=RUN)
  - ready = (state==RUN)
- Reset: state=PLL_RESET, cycle counter=0, pll_rst=1, video_rst=1, ready=0, lock_lost_sticky=0, both counts=0.
- A single cycle counter cnt is shared by the states and cleared on every state transition.
- PLL_RESET:
  - lk_s is ignored.
  - cnt increments each cycle.
  - When cnt==PLL_RST_CYCLES-1, go to WAIT_LOCK.
  - pll_rst is therefore high for exactly PLL_RST_CYCLES cycles.
- WAIT_LOCK:
  - If lk_s==1, go to HOLDOFF.
  - Otherwise, if cnt==LOCK_TIMEOUT-1, go to PLL_RESET and increment timeout_count.
  - Otherwise, cnt increments.
- HOLDOFF:
  - If lk_s==0, go to WAIT_LOCK. This is a glitch, not counted, and the timeout restarts from 0.
  - Otherwise, if cnt==HOLDOFF_CYCLES-1, go to RUN.
  - Otherwise, cnt increments.
- RUN:
  - If lk_s==0, go to PLL_RESET, set lock_lost_sticky, and increment lock_lost_count.
  - video_rst rises in the cycle after lk_s is seen low.
- Latency: if locked_in is high and stable from sampling edge E0 while in WAIT_LOCK, the state is HOLDOFF after edge E0+SYNC_STAGES-1+1, and video_rst falls after edge E0+SYNC_STAGES+HOLDOFF_CYCLES.
- Counters saturate at 2^CNT_W-1 and never wrap.
- clr_status=1 clears lock_lost_sticky and both counts in the next cycle.
- If clr_status coincides with an increment event, that counter becomes 1, and the sticky flag becomes 1 if the event was a lock loss. An event is never lost.
- clr_status has no effect on the state machine.
- rst asserted mid-operation (any state): the next state is PLL_RESET with all outputs at reset values.

Test Plan:
Parameters for all scenarios: SYNC_STAGES=2, PLL_RST_CYCLES=4, LOCK_TIMEOUT=20, HOLDOFF_CYCLES=8, CNT_W=4.
1. Reset released, locked_in driven high 3 cycles after pll_rst falls -> pll_rst high exactly 4 cycles; video_rst falls exactly 2+8 edges after locked_in is first sampled high; ready=1.
2. locked_in held low -> pll_rst re-pulses (4 cycles) every 24 cycles; timeout_count=1,2,3; after 20 timeouts it saturates at 15.
3. In HOLDOFF, locked_in low for 1 cycle at holdoff count 5 -> returns to WAIT_LOCK with no counter change; a full 8 stable cycles is then needed before ready.
4. In RUN, locked_in drops -> video_rst=1 and pll_rst=1 within 3 cycles; lock_lost_sticky=1; lock_lost_count=1; relock leads to ready again.
5. clr_status pulsed in the same cycle as a lock loss, with lock_lost_count=5 -> lock_lost_count=1 and sticky=1. clr_status alone -> all status=0, ready unchanged.
6. rst asserted for 1 cycle while in RUN -> next cycle state=PLL_RESET, video_rst=1, counts=0, and the full sequence repeats.

Source files
------------

// File: rtl/video_pll_lock_ctrl.sv
// Video PLL reset/lock controller on the free-running board clock: pulses PLL reset,
// waits for a stable synchronized lock, releases video reset and tracks lock-loss status.
module video_pll_lock_ctrl #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT   = 65536,
  parameter int unsigned HOLDOFF_CYCLES = 1024,
  parameter int unsigned CNT_W          = 8
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             locked_in,
  input  logic             clr_status,
  output logic             pll_rst,
  output logic             video_rst,
  output logic             ready,
  output logic             lock_lost_sticky,
  output logic [CNT_W-1:0] lock_lost_count,
  output logic [CNT_W-1:0] timeout_count
);

  localparam int unsigned MaxA    = (PLL_RST_CYCLES > HOLDOFF_CYCLES) ? PLL_RST_CYCLES
                                                                      : HOLDOFF_CYCLES;
  localparam int unsigned MaxCyc  = (LOCK_TIMEOUT > MaxA) ? LOCK_TIMEOUT : MaxA;
  localparam int unsigned CntBits = ($clog2(MaxCyc) < 1) ? 1 : $clog2(MaxCyc);

  typedef logic [CntBits-1:0] cnt_t;
  typedef logic [CNT_W-1:0]   stat_t;

  localparam cnt_t  PllRstLast  = cnt_t'(PLL_RST_CYCLES - 1);
  localparam cnt_t  TimeoutLast = cnt_t'(LOCK_TIMEOUT - 1);
  localparam cnt_t  HoldoffLast = cnt_t'(HOLDOFF_CYCLES - 1);
  localparam stat_t StatSat     = '1;

  typedef enum logic [1:0] {StPllReset, StWaitLock, StHoldoff, StRun} state_e;

  state_e                 state_q, state_d;
  cnt_t                   cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   lk_s;
  logic                   pll_rst_q, video_rst_q, ready_q;
  logic                   sticky_q, sticky_d;
  stat_t                  lost_cnt_q, lost_cnt_d;
  stat_t                  tmo_cnt_q, tmo_cnt_d;
  logic                   ev_timeout, ev_lost;

  // locked_in is asynchronous; nothing else may look at it
  assign sync_d = {sync_q[SYNC_STAGES-2:0], locked_in};
  assign lk_s   = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + cnt_t'(1);
    ev_timeout = 1'b0;
    ev_lost    = 1'b0;
    unique case (state_q)
      StPllReset: begin
        if (cnt_q == PllRstLast) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end
      end
      StWaitLock: begin
        if (lk_s) begin
          state_d = StHoldoff;
          cnt_d   = '0;
        end else if (cnt_q == TimeoutLast) begin
          state_d    = StPllReset;
          cnt_d      = '0;
          ev_timeout = 1'b1;
        end
      end
      StHoldoff: begin
        if (!lk_s) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end else if (cnt_q == HoldoffLast) begin
          state_d = StRun;
          cnt_d   = '0;
        end
      end
      StRun: begin
        cnt_d = '0;
        if (!lk_s) begin
          state_d = StPllReset;
          ev_lost = 1'b1;
        end
      end
      default: begin
        state_d = StPllReset;
        cnt_d   = '0;
      end
    endcase
  end

  // A clear coinciding with an event restarts the counter at 1 so the event is kept
  always_comb begin
    sticky_d   = sticky_q;
    lost_cnt_d = lost_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    if (clr_status) begin
      sticky_d   = ev_lost;
      lost_cnt_d = ev_lost ? stat_t'(1) : '0;
      tmo_cnt_d  = ev_timeout ? stat_t'(1) : '0;
    end else begin
      if (ev_lost) begin
        sticky_d = 1'b1;
        if (lost_cnt_q != StatSat) lost_cnt_d = lost_cnt_q + stat_t'(1);
      end
      if (ev_timeout && (tmo_cnt_q != StatSat)) tmo_cnt_d = tmo_cnt_q + stat_t'(1);
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q     <= StPllReset;
      cnt_q       <= '0;
      sync_q      <= '0;
      pll_rst_q   <= 1'b1;
      video_rst_q <= 1'b1;
      ready_q     <= 1'b0;
      sticky_q    <= 1'b0;
      lost_cnt_q  <= '0;
      tmo_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sync_q      <= sync_d;
      pll_rst_q   <= (state_d == StPllReset);
      video_rst_q <= (state_d != StRun);
      ready_q     <= (state_d == StRun);
      sticky_q    <= sticky_d;
      lost_cnt_q  <= lost_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
    end
  end

  assign pll_rst          = pll_rst_q;
  assign video_rst        = video_rst_q;
  assign ready            = ready_q;
  assign lock_lost_sticky = sticky_q;
  assign lock_lost_count  = lost_cnt_q;
  assign timeout_count    = tmo_cnt_q;

endmodule

// File: tb/tb_video_pll_lock_ctrl.sv
// Directed bench for video_pll_lock_ctrl with small parameters (4/20/8 cycles, 4-bit counts).
module tb_video_pll_lock_ctrl;

  localparam int unsigned SyncStages = 2;
  localparam int unsigned PllRstCyc  = 4;
  localparam int unsigned LockTmo    = 20;
  localparam int unsigned Holdoff    = 8;
  localparam int unsigned CntW       = 4;

  logic            refclk = 1'b0;
  logic            rst;
  logic            locked_in;
  logic            clr_status;
  logic            pll_rst;
  logic            video_rst;
  logic            ready;
  logic            lock_lost_sticky;
  logic [CntW-1:0] lock_lost_count;
  logic [CntW-1:0] timeout_count;

  int n_checks = 0;
  int n_pass   = 0;
  int n;

  video_pll_lock_ctrl #(
    .SYNC_STAGES   (SyncStages),
    .PLL_RST_CYCLES(PllRstCyc),
    .LOCK_TIMEOUT  (LockTmo),
    .HOLDOFF_CYCLES(Holdoff),
    .CNT_W         (CntW)
  ) dut (
    .refclk          (refclk),
    .rst             (rst),
    .locked_in       (locked_in),
    .clr_status      (clr_status),
    .pll_rst         (pll_rst),
    .video_rst       (video_rst),
    .ready           (ready),
    .lock_lost_sticky(lock_lost_sticky),
    .lock_lost_count (lock_lost_count),
    .timeout_count   (timeout_count)
  );

  always #5 refclk = ~refclk;

  // Inputs change and outputs are sampled on the falling edge
  task automatic tick(input int cycles = 1);
    for (int i = 0; i < cycles; i++) begin
      @(posedge refclk);
      @(negedge refclk);
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic wait_ready(input int limit, output int cycles);
    cycles = 0;
    while (ready !== 1'b1 && cycles < limit) begin
      tick();
      cycles++;
    end
  endtask

  task automatic wait_pll_low(input int limit, output int cycles);
    cycles = 0;
    while (pll_rst === 1'b1 && cycles < limit) begin
      tick();
      cycles++;
    end
  endtask

  // Lock drops, FSM falls back through PLL reset, then relocks
  task automatic lose_and_relock(input string tag);
    int c;
    locked_in = 1'b0;
    tick(3);
    check({tag, "_pll_rst"}, pll_rst, 1);
    locked_in = 1'b1;
    wait_ready(100, c);
    check({tag, "_relock"}, ready, 1);
  endtask

  initial begin
    rst        = 1'b1;
    locked_in  = 1'b0;
    clr_status = 1'b0;
    tick(3);
    check("rst_pll_rst", pll_rst, 1);
    check("rst_video_rst", video_rst, 1);
    check("rst_ready", ready, 0);
    check("rst_sticky", lock_lost_sticky, 0);
    check("rst_lost_cnt", lock_lost_count, 0);
    check("rst_tmo_cnt", timeout_count, 0);

    // Power-up lock: pll_rst width, then lock-to-release latency
    rst = 1'b0;
    wait_pll_low(100, n);
    check("s1_pll_rst_width", n, 4);
    tick(3);
    locked_in = 1'b1;
    n = 0;
    while (video_rst === 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check("s1_release_latency", n, 11);
    check("s1_ready", ready, 1);
    check("s1_pll_rst_low", pll_rst, 0);

    // Lock loss in RUN
    locked_in = 1'b0;
    tick(2);
    check("s4_ready_before", ready, 1);
    tick();
    check("s4_video_rst", video_rst, 1);
    check("s4_pll_rst", pll_rst, 1);
    check("s4_sticky", lock_lost_sticky, 1);
    check("s4_lost_cnt", lock_lost_count, 1);
    locked_in = 1'b1;
    wait_ready(100, n);
    check("s4_relock", ready, 1);
    check("s4_tmo_cnt", timeout_count, 0);

    // clr_status alone leaves the FSM alone
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    check("s5_clr_sticky", lock_lost_sticky, 0);
    check("s5_clr_lost_cnt", lock_lost_count, 0);
    check("s5_clr_tmo_cnt", timeout_count, 0);
    check("s5_clr_ready", ready, 1);

    for (int i = 0; i < 5; i++) lose_and_relock("s5_loss");
    check("s5_lost_cnt5", lock_lost_count, 5);
    check("s5_sticky5", lock_lost_sticky, 1);

    // Clear lands on the same edge as the lock-loss event
    locked_in = 1'b0;
    tick(2);
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    check("s5_coinc_lost_cnt", lock_lost_count, 1);
    check("s5_coinc_sticky", lock_lost_sticky, 1);
    check("s5_coinc_pll_rst", pll_rst, 1);
    locked_in = 1'b1;
    wait_ready(100, n);
    check("s5_relock", ready, 1);

    // Mid-RUN reset, then a one-cycle glitch at holdoff count 5
    rst       = 1'b1;
    locked_in = 1'b0;
    tick();
    rst = 1'b0;
    check("s6_pll_rst", pll_rst, 1);
    check("s6_video_rst", video_rst, 1);
    check("s6_ready", ready, 0);
    check("s6_lost_cnt", lock_lost_count, 0);
    check("s6_sticky", lock_lost_sticky, 0);
    wait_pll_low(100, n);
    check("s6_pll_rst_width", n, 4);
    locked_in = 1'b1;
    tick(6);
    locked_in = 1'b0;
    tick();
    locked_in = 1'b1;
    tick();
    check("s3_not_ready", ready, 0);
    wait_ready(100, n);
    check("s3_glitch_latency", n, 10);
    check("s3_tmo_cnt", timeout_count, 0);
    check("s3_lost_cnt", lock_lost_count, 0);

    // No lock: periodic retry and saturating timeout count
    rst       = 1'b1;
    locked_in = 1'b0;
    tick();
    rst = 1'b0;
    tick(4);
    check("s2_pll_rst_fall", pll_rst, 0);
    tick(19);
    check("s2_before_tmo", timeout_count, 0);
    check("s2_before_tmo_pll", pll_rst, 0);
    tick();
    check("s2_tmo1", timeout_count, 1);
    check("s2_tmo1_pll", pll_rst, 1);
    tick(3);
    check("s2_pulse_hi", pll_rst, 1);
    tick();
    check("s2_pulse_lo", pll_rst, 0);
    tick(20);
    check("s2_tmo2", timeout_count, 2);
    tick(24);
    check("s2_tmo3", timeout_count, 3);
    tick(24 * 12);
    check("s2_tmo15", timeout_count, 15);
    tick(24 * 5);
    check("s2_tmo_sat", timeout_count, 15);
    check("s2_no_loss", lock_lost_count, 0);
    check("s2_not_ready", ready, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
